uart_rx_byte: RTL and testbench

Receive-side UART deframer for the DE2 top level. It samples `iUART_RXD` (8N1, LSB first, idle high) with a free-running 50 MHz clock and presents each received byte on a parallel bus with a one-cycle valid strobe. A framing-error strobe is raised instead when the stop bit is bad. It is the receive counterpart to the transmit path on `oUART_TXD`, and feeds the LED/7-seg display logic in `DE2_TOP`.

---
 rtl/uart_rx_byte.sv | 153 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receive deframer: synchronizes the serial line, samples mid-bit and
// presents each byte with a one-cycle valid strobe, or a framing-error strobe.
module uart_rx_byte #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       iCLK_50,
  input  logic       iRST_N,
  input  logic       iRXD,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oBUSY
);

  localparam int unsigned CPB  = CLK_HZ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CntW = $clog2(CPB);

  localparam logic [CntW-1:0] CntBitLast  = CntW'(CPB - 1);
  localparam logic [CntW-1:0] CntHalfLast = CntW'(HALF - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StStop     = 3'd3;
  localparam logic [2:0] StWaitIdle = 3'd4;

  logic            sync1_q;
  logic            rx_s_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bitn_q, bitn_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // Both synchronizer flops reset to the idle (mark) level.
  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= iRXD;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == CntHalfLast) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = StData;
            bitn_d  = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StData: begin
        if (cnt_q == CntBitLast) begin
          cnt_d = '0;
          // LSB arrives first, so shifting right leaves the byte aligned.
          sh_d  = {rx_s_q, sh_q[7:1]};
          if (bitn_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StStop: begin
        if (cnt_q == CntBitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      // Hold off until the line returns to mark so a break is not decoded as 0x00 frames.
      StWaitIdle: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bitn_q  <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign oDATA      = data_q;
  assign oVALID     = valid_q;
  assign oFRAME_ERR = ferr_q;
  assign oBUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomized scoreboard bench for uart_rx_byte: frames are driven on the line and
// the expected byte/error and strobe cycle are queued for an independent monitor.
module tb_uart_rx_byte;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = 8;
  localparam int unsigned CPB_DEF  = 50_000_000 / 115200;
  localparam int unsigned BLEN_DEF = (CPB_DEF * 103) / 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd, rxd2;
  logic [7:0] data, data2;
  logic       valid, ferr, busy;
  logic       valid2, ferr2, busy2;

  always #5 clk = ~clk;

  uart_rx_byte #(.CLK_HZ(16), .BAUD(1)) u_dut (
    .iCLK_50   (clk),
    .iRST_N    (rst_n),
    .iRXD      (rxd),
    .oDATA     (data),
    .oVALID    (valid),
    .oFRAME_ERR(ferr),
    .oBUSY     (busy)
  );

  uart_rx_byte u_dut_def (
    .iCLK_50   (clk),
    .iRST_N    (rst_n),
    .iRXD      (rxd2),
    .oDATA     (data2),
    .oVALID    (valid2),
    .oFRAME_ERR(ferr2),
    .oBUSY     (busy2)
  );

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  last_good;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          v2_cnt = 0;
  int          f2_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: any strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid || ferr) begin
      check("strobes exclusive", {31'b0, valid & ferr}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected strobe: valid=%b ferr=%b data=0x%0h, expected none (cycle %0d)",
                 valid, ferr, data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe kind (1=frame err)", {31'b0, ferr}, {31'b0, mon_e.is_err});
        check("strobe cycle", cyc, mon_e.at);
        check("oDATA at strobe", {24'b0, data}, {24'b0, mon_e.data});
      end
    end
    if (valid2) v2_cnt++;
    if (ferr2) f2_cnt++;
  end

  // Reference: a strobe appears HALF+9*CPB cycles after the start edge reaches the FSM
  // (2-flop synchronizer plus one IDLE decision cycle); the stop bit decides its kind.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t       e;
    logic [9:0] bits;
    bits     = {stop_ok, b, 1'b0};
    if (stop_ok) last_good = b;
    e.is_err = !stop_ok;
    e.data   = last_good;
    e.at     = cyc + 3 + HALF + 9 * CPB;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int unsigned n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int         bc;
    logic [9:0] abits;
    logic [9:0] dbits;

    rst_n     = 1'b0;
    rxd       = 1'b1;
    rxd2      = 1'b1;
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset oDATA", {24'b0, data}, 32'h00);
    check("reset oVALID", {31'b0, valid}, 32'd0);
    check("reset oFRAME_ERR", {31'b0, ferr}, 32'd0);
    check("reset oBUSY", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // Single byte
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("A5 consumed", exp_q.size(), 32'd0);
    check("busy low after A5", {31'b0, busy}, 32'd0);

    // Back-to-back, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("back-to-back consumed", exp_q.size(), 32'd0);

    // Glitch rejection
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd = 1'b1;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    #1;
    check("glitch busy window ok", {31'b0, (bc >= 1 && bc <= HALF + 3)}, 32'd1);
    check("busy low after glitch", {31'b0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1);
    idle(10);

    // Framing error followed by a break
    send_frame(8'h55, 1'b0);
    repeat (400) @(posedge clk);
    #1;
    check("busy held during break", {31'b0, busy}, 32'd1);
    check("oDATA kept after frame err", {24'b0, data}, {24'b0, last_good});
    idle(6);
    check("busy low after break", {31'b0, busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    idle(10);

    // Reset during data bit 4 of 0xC3
    abits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd = abits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = abits[5];
    repeat (HALF) @(posedge clk);
    #1;
    check("busy during data bit 4", {31'b0, busy}, 32'd1);
    rst_n     = 1'b0;
    rxd       = 1'b1;
    last_good = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid-frame reset oDATA", {24'b0, data}, 32'h00);
    check("mid-frame reset oVALID", {31'b0, valid}, 32'd0);
    check("mid-frame reset oFRAME_ERR", {31'b0, ferr}, 32'd0);
    check("mid-frame reset oBUSY", {31'b0, busy}, 32'd0);
    idle(20);
    send_frame(8'hC3, 1'b1);
    idle(10);

    // Randomized frames with occasional bad stop bits and random gaps
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit         ok;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      idle(ok ? $urandom_range(0, 12) : $urandom_range(2, 12));
    end

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("all expected strobes seen", exp_q.size(), 32'd0);

    // Default parameters, bit period stretched by 3%
    check("default dut quiet before frame", v2_cnt + f2_cnt, 32'd0);
    dbits = {1'b1, 8'h7E, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd2 = dbits[i];
      repeat (BLEN_DEF) @(posedge clk);
      #1;
    end
    rxd2 = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    check("default dut valid count", v2_cnt, 32'd1);
    check("default dut frame err count", f2_cnt, 32'd0);
    check("default dut oDATA", {24'b0, data2}, 32'h7E);
    check("default dut busy low", {31'b0, busy2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
